// File: rtl/scaler_linear_h_lb.sv
// Multi-channel horizontal linear/nearest scaler with a ping-pong line buffer.
// The write side captures one line per bank. At line end an idle read engine
// takes that bank and walks a fixed-point accumulator across it, issuing one
// two-tap interpolation per clock into a 4-stage arithmetic pipeline.
module scaler_linear_h_lb #(
    parameter int CHANNELS    = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int PIXEL_STEP  = 4096,
    parameter int MAX_LINE    = 2048
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     scale_step,
    input  logic [15:0]                     out_width,
    input  logic                            mode,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
    output logic                            de_o,
    output logic                            hs_o,
    output logic                            vs_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int FRAC_W = $clog2(PIXEL_STEP);
    localparam int AW     = $clog2(MAX_LINE);
    localparam int CW     = CHANNELS * PIXEL_WIDTH;
    localparam int ACC_W  = AW + FRAC_W + 1;
    localparam int WW     = FRAC_W + 1;
    localparam int MW     = PIXEL_WIDTH + WW;
    localparam int SW     = MW + 1;

    localparam logic [WW-1:0] STEP_W = WW'(PIXEL_STEP);
    localparam logic [WW-1:0] HALF_W = WW'(PIXEL_STEP / 2);
    localparam logic [AW:0]   MAX_N  = (AW + 1)'(MAX_LINE);
    localparam logic [AW:0]   ONE_N  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_A  = AW'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Line buffer: bank bit is the MSB of the address
    logic [CW-1:0] mem_q [2*MAX_LINE];

    // Write side
    logic [AW:0]  wr_ptr_q, wr_ptr_d, wa_s;
    logic         wr_bank_q, de_prev_q, vs_pend_q, err_q;
    logic         in_range_s, wr_en_s, line_end_s, start_s;

    // Read engine
    state_t              state_q;
    logic [ACC_W-1:0]    pos_q;
    logic [15:0]         j_q, ow_q, step_q;
    logic                mode_q, rd_bank_q, eng_vs_q, busy_q;
    logic [AW:0]         len_q, idx_s;
    logic [FRAC_W-1:0]   frac_s;
    logic [AW-1:0]       a0_s, a1_s;
    logic [WW-1:0]       w0_s, w1_s;
    logic                stop_s, issue_s, busy_d;

    // Pipeline
    logic                s1_vld_q, s1_first_q, s1_vs_q;
    logic [AW-1:0]       s1_a0_q, s1_a1_q;
    logic [WW-1:0]       s1_w0_q, s1_w1_q;
    logic                s2_vld_q, s2_first_q, s2_vs_q;
    logic [CW-1:0]       s2_p0_q, s2_p1_q;
    logic [WW-1:0]       s2_w0_q, s2_w1_q;
    logic                s3_vld_q, s3_first_q, s3_vs_q;
    logic [MW-1:0]       s3_m0_q [CHANNELS];
    logic [MW-1:0]       s3_m1_q [CHANNELS];
    logic                s4_vld_q, s4_first_q, s4_vs_q;
    logic [CW-1:0]       s4_pix_q;
    logic [CW-1:0]       do_q;
    logic                de_q, hs_q, vs_q;

    // Write address generation, overflow detection and line-end/start decision
    always_comb begin
        wa_s       = hs_i ? {(AW + 1){1'b0}} : wr_ptr_q;
        in_range_s = (wa_s < MAX_N);
        wr_en_s    = de_i & in_range_s;
        wr_ptr_d   = in_range_s ? (wa_s + ONE_N) : wa_s;
        line_end_s = de_prev_q & ~de_i;
        start_s    = line_end_s & (state_q == ST_IDLE);
    end

    // Write pointer, bank toggle, pending frame flag and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= {(AW + 1){1'b0}};
            wr_bank_q <= 1'b0;
            de_prev_q <= 1'b0;
            vs_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            de_prev_q <= de_i;
            if (de_i) begin
                wr_ptr_q <= wr_ptr_d;
            end
            if (start_s) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (de_i & vs_i) begin
                vs_pend_q <= 1'b1;
            end else if (start_s) begin
                vs_pend_q <= 1'b0;
            end
            if ((de_i & ~in_range_s) | (line_end_s & ~start_s)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Line buffer write port and the two synchronous read ports
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[{wr_bank_q, wa_s[AW-1:0]}] <= di_i;
        end
        s2_p0_q <= mem_q[{rd_bank_q, s1_a0_q}];
        s2_p1_q <= mem_q[{rd_bank_q, s1_a1_q}];
    end

    // Tap addresses with right-edge clamp, weights, and stop condition
    always_comb begin
        idx_s   = pos_q[ACC_W-1:FRAC_W];
        frac_s  = pos_q[FRAC_W-1:0];
        stop_s  = (j_q == ow_q) || (idx_s >= len_q);
        issue_s = (state_q == ST_RUN) && !stop_s;
        a0_s    = idx_s[AW-1:0];
        if ((idx_s + ONE_N) >= len_q) begin
            a1_s = idx_s[AW-1:0];
        end else begin
            a1_s = idx_s[AW-1:0] + ONE_A;
        end
        if (mode_q) begin
            if ({1'b0, frac_s} >= HALF_W) begin
                w1_s = STEP_W;
            end else begin
                w1_s = {WW{1'b0}};
            end
        end else begin
            w1_s = {1'b0, frac_s};
        end
        w0_s   = STEP_W - w1_s;
        busy_d = start_s | issue_s | s1_vld_q | s2_vld_q | s3_vld_q | s4_vld_q;
    end

    // Read engine FSM: latches config at start, steps accumulator, issues taps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pos_q      <= {ACC_W{1'b0}};
            j_q        <= 16'd0;
            ow_q       <= 16'd0;
            step_q     <= 16'd0;
            mode_q     <= 1'b0;
            len_q      <= {(AW + 1){1'b0}};
            rd_bank_q  <= 1'b0;
            eng_vs_q   <= 1'b0;
            busy_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_a0_q    <= {AW{1'b0}};
            s1_a1_q    <= {AW{1'b0}};
            s1_w0_q    <= {WW{1'b0}};
            s1_w1_q    <= {WW{1'b0}};
        end else begin
            busy_q   <= busy_d;
            s1_vld_q <= issue_s;
            if (issue_s) begin
                s1_a0_q    <= a0_s;
                s1_a1_q    <= a1_s;
                s1_w0_q    <= w0_s;
                s1_w1_q    <= w1_s;
                s1_first_q <= (j_q == 16'd0);
                s1_vs_q    <= eng_vs_q & (j_q == 16'd0);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q   <= ST_RUN;
                        pos_q     <= {ACC_W{1'b0}};
                        j_q       <= 16'd0;
                        step_q    <= scale_step;
                        ow_q      <= out_width;
                        mode_q    <= mode;
                        len_q     <= wr_ptr_q;
                        rd_bank_q <= wr_bank_q;
                        eng_vs_q  <= vs_pend_q;
                    end
                end
                ST_RUN: begin
                    if (stop_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        pos_q <= pos_q + ACC_W'(step_q);
                        j_q   <= j_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Multiply, rounded sum and output register stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_vs_q    <= 1'b0;
            s2_w0_q    <= {WW{1'b0}};
            s2_w1_q    <= {WW{1'b0}};
            s3_vld_q   <= 1'b0;
            s3_first_q <= 1'b0;
            s3_vs_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                s3_m0_q[c] <= {MW{1'b0}};
                s3_m1_q[c] <= {MW{1'b0}};
            end
            s4_vld_q   <= 1'b0;
            s4_first_q <= 1'b0;
            s4_vs_q    <= 1'b0;
            s4_pix_q   <= {CW{1'b0}};
            do_q       <= {CW{1'b0}};
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            s2_vld_q   <= s1_vld_q;
            s2_first_q <= s1_first_q;
            s2_vs_q    <= s1_vs_q;
            s2_w0_q    <= s1_w0_q;
            s2_w1_q    <= s1_w1_q;
            s3_vld_q   <= s2_vld_q;
            s3_first_q <= s2_first_q;
            s3_vs_q    <= s2_vs_q;
            for (int c = 0; c < CHANNELS; c++) begin
                s3_m0_q[c] <= MW'(s2_p0_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]) * MW'(s2_w0_q);
                s3_m1_q[c] <= MW'(s2_p1_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]) * MW'(s2_w1_q);
            end
            s4_vld_q   <= s3_vld_q;
            s4_first_q <= s3_first_q;
            s4_vs_q    <= s3_vs_q;
            // w0 + w1 == PIXEL_STEP, so the shifted sum always fits a channel
            for (int c = 0; c < CHANNELS; c++) begin
                s4_pix_q[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= PIXEL_WIDTH'(
                    (SW'(s3_m0_q[c]) + SW'(s3_m1_q[c]) + SW'(HALF_W)) >> FRAC_W);
            end
            de_q <= s4_vld_q;
            hs_q <= s4_vld_q & s4_first_q;
            vs_q <= s4_vld_q & s4_vs_q;
            if (s4_vld_q) begin
                do_q <= s4_pix_q;
            end
        end
    end

    assign do_o   = do_q;
    assign de_o   = de_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_scaler_linear_h_lb.sv
// Self-checking bench for scaler_linear_h_lb: directed and random lines are
// compared against a closed-form model (pos = j * step) of the scaler.
module tb_scaler_linear_h_lb;

    localparam int CH   = 3;
    localparam int PW   = 8;
    localparam int CW   = CH * PW;
    localparam int STEP = 4096;
    localparam int MAXL = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   scale_step, out_width;
    logic          mode;
    logic [CW-1:0] di_i;
    logic          de_i, hs_i, vs_i;
    logic [CW-1:0] do_o;
    logic          de_o, hs_o, vs_o, busy_o, err_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [CW-1:0] line_buf [0:2099];
    logic [CW-1:0] exp_q [$];

    scaler_linear_h_lb dut (
        .clk(clk), .rst(rst),
        .scale_step(scale_step), .out_width(out_width), .mode(mode),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Two-tap blend of pixels a and b per channel
    function automatic logic [CW-1:0] blend(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input int frac, input bit nearest);
        int w0, w1, p0, p1, v;
        logic [CW-1:0] r;
        r = '0;
        if (nearest) w1 = (frac >= STEP / 2) ? STEP : 0;
        else         w1 = frac;
        w0 = STEP - w1;
        for (int c = 0; c < CH; c++) begin
            p0 = int'(a[c*PW +: PW]);
            p1 = int'(b[c*PW +: PW]);
            v  = (p0 * w0 + p1 * w1 + STEP / 2) / STEP;
            r[c*PW +: PW] = PW'(v);
        end
        return r;
    endfunction

    task automatic build_expected(input int len, input int step, input int ow, input bit nearest);
        int n, idx, frac, i1;
        longint pos;
        n = (len > MAXL) ? MAXL : len;
        exp_q.delete();
        for (int j = 0; j < ow; j++) begin
            pos  = longint'(j) * longint'(step);
            idx  = int'(pos / STEP);
            frac = int'(pos % STEP);
            if (idx > n - 1) break;
            i1 = (idx + 1 > n - 1) ? n - 1 : idx + 1;
            exp_q.push_back(blend(line_buf[idx], line_buf[i1], frac, nearest));
        end
    endtask

    task automatic set_cfg(input int step, input int ow, input bit m);
        scale_step = 16'(step);
        out_width  = 16'(ow);
        mode       = m;
    endtask

    // Drives line_buf[0..n-1] with hs on the first pixel; returns at the
    // falling edge that drops de_i, so the next rising edge is the line end
    task automatic send_line(input int n, input bit vs_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            de_i = 1'b1;
            hs_i = (i == 0);
            vs_i = (i == 0) && vs_first;
            di_i = line_buf[i];
        end
        @(negedge clk);
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
    endtask

    // Watches the output from the line-end edge for a bounded window
    task automatic collect(input string name, input bit vs_exp, input bit err_exp);
        int k, first_cyc, last_cyc, budget;
        logic exp_hs, exp_vs;
        k = 0; first_cyc = -1; last_cyc = -1;
        budget = exp_q.size() + 30;
        @(posedge clk);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            if (de_o === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    vectors++;
                    if (busy_o !== 1'b1) begin
                        miscompares++;
                        $display("FAIL %s busy_o at first output = %b, required 1", name, busy_o);
                    end
                end
                last_cyc = cyc;
                vectors++;
                if (k >= exp_q.size()) begin
                    miscompares++;
                    $display("FAIL %s extra output #%0d do_o=%h, required none", name, k, do_o);
                end else begin
                    exp_hs = (k == 0);
                    exp_vs = (k == 0) && vs_exp;
                    if (do_o !== exp_q[k] || hs_o !== exp_hs || vs_o !== exp_vs) begin
                        miscompares++;
                        $display("FAIL %s out#%0d do_o=%h hs=%b vs=%b, required do_o=%h hs=%b vs=%b",
                                 name, k, do_o, hs_o, vs_o, exp_q[k], exp_hs, exp_vs);
                    end
                end
                k++;
            end
        end
        vectors++;
        if (k != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s output count=%0d, required %0d", name, k, exp_q.size());
        end
        if (exp_q.size() > 0) begin
            vectors++;
            if (first_cyc != 5) begin
                miscompares++;
                $display("FAIL %s first de_o at clk %0d after line end, required 5", name, first_cyc);
            end
            vectors++;
            if (last_cyc - first_cyc + 1 != k) begin
                miscompares++;
                $display("FAIL %s de_o span=%0d for %0d outputs, required contiguous", name,
                         last_cyc - first_cyc + 1, k);
            end
            vectors++;
            if (do_o !== exp_q[exp_q.size() - 1]) begin
                miscompares++;
                $display("FAIL %s do_o hold=%h, required %h", name, do_o, exp_q[exp_q.size() - 1]);
            end
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_o after line=%b, required 0", name, busy_o);
        end
        vectors++;
        if (err_o !== err_exp) begin
            miscompares++;
            $display("FAIL %s err_o=%b, required %b", name, err_o, err_exp);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (de_o === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL %s de_o seen=%b, required 0", name, seen);
        end
    endtask

    task automatic check_cleared(input string name);
        vectors++;
        if (do_o !== '0 || de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0 ||
            busy_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s do=%h de=%b hs=%b vs=%b busy=%b err=%b, required all 0",
                     name, do_o, de_o, hs_o, vs_o, busy_o, err_o);
        end
    endtask

    // Fill with channel-0 value v and random upper channels
    task automatic put_pix(input int i, input int v);
        logic [CW-1:0] w;
        w = CW'($urandom);
        w[PW-1:0] = PW'(v);
        line_buf[i] = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; di_i = '0;
        set_cfg(4096, 4, 1'b0);
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            de_i = 1'b1;
            hs_i = (i == 0);
            di_i = CW'($urandom);
        end
        @(negedge clk);
        de_i = 1'b0; hs_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("reset_partial_line", 20);
    endtask

    task automatic test_copy();
        for (int i = 0; i < 8; i++) put_pix(i, 10 * (i + 1));
        set_cfg(4096, 8, 1'b0);
        build_expected(8, 4096, 8, 1'b0);
        send_line(8, 1'b0);
        collect("copy_1to1", 1'b0, 1'b0);
    endtask

    task automatic test_upscale();
        for (int i = 0; i < 4; i++) put_pix(i, 100 * i);
        set_cfg(2048, 8, 1'b0);
        build_expected(4, 2048, 8, 1'b0);
        send_line(4, 1'b0);
        collect("upscale_linear", 1'b0, 1'b0);
    endtask

    task automatic test_downscale();
        for (int i = 0; i < 8; i++) put_pix(i, 10 * (i + 1));
        set_cfg(8192, 8, 1'b0);
        build_expected(8, 8192, 8, 1'b0);
        send_line(8, 1'b0);
        collect("downscale_early_stop", 1'b0, 1'b0);
    endtask

    task automatic test_nearest();
        put_pix(0, 0);
        put_pix(1, 100);
        set_cfg(2048, 4, 1'b1);
        build_expected(2, 2048, 4, 1'b1);
        send_line(2, 1'b0);
        collect("nearest", 1'b0, 1'b0);
        set_cfg(2048, 4, 1'b0);
        build_expected(2, 2048, 4, 1'b0);
        send_line(2, 1'b0);
        collect("nearest_vs_linear", 1'b0, 1'b0);
    endtask

    task automatic test_multichannel();
        line_buf[0] = {8'd16, 8'd255, 8'd0};
        line_buf[1] = {8'd16, 8'd55, 8'd100};
        set_cfg(2048, 3, 1'b0);
        build_expected(2, 2048, 3, 1'b0);
        send_line(2, 1'b1);
        collect("multichannel_vs", 1'b1, 1'b0);
    endtask

    task automatic test_zero_width();
        for (int i = 0; i < 5; i++) put_pix(i, i + 1);
        set_cfg(4096, 0, 1'b0);
        build_expected(5, 4096, 0, 1'b0);
        send_line(5, 1'b0);
        collect("zero_width", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n, step, ow;
        bit m, v;
        for (int t = 0; t < 12; t++) begin
            n    = $urandom_range(1, 40);
            step = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(512, 12288);
            ow   = $urandom_range(0, 40);
            m    = 1'($urandom_range(0, 1));
            v    = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) line_buf[i] = CW'($urandom);
            set_cfg(step, ow, m);
            build_expected(n, step, ow, m);
            send_line(n, v);
            collect("random_line", v, 1'b0);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++) line_buf[i] = CW'($urandom);
        set_cfg(1024, 100, 1'b0);
        build_expected(4, 1024, 100, 1'b0);
        send_line(4, 1'b0);
        fork
            collect("overrun", 1'b0, 1'b1);
            begin
                for (int i = 0; i < 4; i++) line_buf[i] = CW'($urandom);
                send_line(4, 1'b0);
            end
        join
    endtask

    task automatic test_reset_mid_output();
        for (int i = 0; i < 4; i++) line_buf[i] = CW'($urandom) | CW'(1);
        set_cfg(1024, 100, 1'b0);
        send_line(4, 1'b0);
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("reset_mid_output");
        @(negedge clk);
        rst = 1'b0;
        check_quiet("reset_no_resume", 20);
        for (int i = 0; i < 6; i++) line_buf[i] = CW'($urandom);
        set_cfg(3000, 10, 1'b0);
        build_expected(6, 3000, 10, 1'b0);
        send_line(6, 1'b0);
        collect("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_line_overflow();
        for (int i = 0; i < 2050; i++) line_buf[i] = CW'($urandom);
        set_cfg(65535, 200, 1'b0);
        build_expected(2050, 65535, 200, 1'b0);
        send_line(2050, 1'b0);
        collect("line_overflow_clamp", 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_copy();
        test_upscale();
        test_downscale();
        test_nearest();
        test_multichannel();
        test_zero_width();
        test_random();
        test_overrun();
        test_reset_mid_output();
        test_line_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scaler_linear_h_lb.md
Name: scaler_linear_h_lb

Overview:
- Multi-channel horizontal linear/nearest scaler, next generation of the team's streaming horizontal scaler.
- Each input line is captured into a ping-pong line buffer. Once the line ends, an independent read engine generates a programmable number of output pixels.
- Supports upsizing and downsizing with edge clamping, runtime mode select, and an overrun error flag.
- Sits between the video input formatter and the vertical scaler.

Parameters:
- CHANNELS, 3, number of colour channels packed in one pixel word; all channels use the same weights.
- PIXEL_WIDTH, 8, bits per channel (unsigned).
- PIXEL_STEP, 4096, fixed-point 1.0; must be a power of 2; FRAC_W = log2(PIXEL_STEP).
- MAX_LINE, 2048, depth of each line bank in pixels; AW = log2(MAX_LINE).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- scale_step  in  16  unsigned fixed point, input pixels per output pixel × PIXEL_STEP; sampled at read-engine start.
- out_width  in  16  requested output pixels per line; sampled at read-engine start.
- mode  in  1  0 = linear, 1 = nearest; sampled at read-engine start.
- di_i  in  CHANNELS*PIXEL_WIDTH  input pixel; channel c occupies bits [c*PIXEL_WIDTH +: PIXEL_WIDTH].
- de_i  in  1  input pixel valid; contiguous within a line.
- hs_i  in  1  first pixel of line; qualified by de_i.
- vs_i  in  1  first pixel of frame; qualified by de_i.
- do_o  out  CHANNELS*PIXEL_WIDTH  output pixel.
- de_o  out  1  output pixel valid.
- hs_o  out  1  first output pixel of line.
- vs_o  out  1  first output pixel of frame.
- busy_o  out  1  read engine active.
- err_o  out  1  sticky overrun flag; cleared only by rst.

Behaviour:
- Reset (async):
  - do_o, de_o, hs_o, vs_o, busy_o, err_o = 0.
  - Write address = 0, write bank = 0, read engine idle, pending-vs flag cleared.
  - Reset mid-line discards the partial line; no output follows it.
- Write side:
  - de_i & hs_i sets the write address to 0 and writes di_i there.
  - Each further de_i writes at address+1.
  - Addresses ≥ MAX_LINE are dropped and set err_o.
  - de_i & vs_i latches a frame flag for that line.
- Line end: the first clk with de_i=0 after de_i=1. Line length N = pixels written, clamped to MAX_LINE.
  - If the engine is idle: swap banks, hand N and the frame flag to the engine, and start it next clk.
  - If the engine is busy: set err_o, do not swap; the next line overwrites the same bank.
  - N=0 cannot occur; a line without a leading hs_i continues from the current address.
- Read engine FSM:
  - IDLE -> RUN on start. Latch step, out_width and mode; set accumulator pos = 0 and j = 0.
  - RUN issues one output per clk.
    - idx = pos >> FRAC_W; frac = pos[FRAC_W-1:0].
    - Stop (-> IDLE) when j == out_width or idx > N-1.
    - Otherwise read a0 = min(idx, N-1) and a1 = min(idx+1, N-1) on two read ports.
    - Then pos += step and j += 1.
  - out_width = 0 produces no output; the engine returns to IDLE immediately.
  - The accumulator is AW+FRAC_W+1 bits and must not wrap.
  - busy_o = 1 in RUN and while the pipeline still holds valid data.
- Weights:
  - Linear: w1 = frac, w0 = PIXEL_STEP − frac.
  - Nearest: if frac ≥ PIXEL_STEP/2 then w1 = PIXEL_STEP, w0 = 0; else w1 = 0, w0 = PIXEL_STEP.
- Arithmetic, per channel:
  - out = (p0·w0 + p1·w1 + PIXEL_STEP/2) >> FRAC_W.
  - The result always fits PIXEL_WIDTH because w0 + w1 = PIXEL_STEP and inputs are unsigned. No saturation logic.
- Pipeline: issue -> RAM read (1) -> multiply (1) -> sum (1) -> output register (1).
  - The first de_o comes exactly 5 clk after the line-end clk.
  - Output pixels are contiguous; de_o is high for exactly min(out_width, outputs before stop) clks.
- Output flags:
  - hs_o coincides with the first de_o of each output line.
  - vs_o coincides with that same first de_o when the line carried the frame flag.
  - do_o holds its last value when de_o = 0.
- Simultaneous events: a new line may be written while the engine reads the other bank. A line end in the same clk as the engine's final issue counts as busy (err_o set).

Test Plan:
- 1:1 copy: step 4096, out_width 8, one channel, line 10,20..80 -> de_o for 8 clks, first de_o 5 clk after line end, do_o 10..80, hs_o on first.
- 2× upscale, linear: step 2048, line 0,100,200,300, out_width 8 -> 0,50,100,150,200,250,300,300 (right clamp on last).
- 2× downscale with early stop: step 8192, line 10..80, out_width 8 -> 10,30,50,70 only; de_o high 4 clks.
- Nearest mode: step 2048, line 0,100, out_width 4 -> 0,100,100,100. Same with mode 0 -> 0,50,100,100.
- Multi-channel and vs: CHANNELS=3, pixels {R,G,B} = {0,255,16},{100,55,16}, step 2048, vs_i on first pixel -> outputs {0,255,16},{50,155,16},{100,55,16}, vs_o and hs_o on first output.
- Overrun and reset: two 4-pixel lines 1 clk apart with out_width 100 -> err_o = 1, second line yields no output. Asserting rst mid-output -> all outputs 0 in the same cycle, err_o cleared, next full line scales normally.
